// File: rtl/seq_pkg.sv
// Shared definitions for the memory-game sequencer: state encodings,
// sequence length and LED constants.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    WAIT_IN  = 3'd4,
    GAP      = 3'd5,
    WIN      = 3'd6,
    LOSE     = 3'd7
  } state_e;

  localparam int SEQ_LEN = 16;

  localparam logic [3:0] LED_ALL = 4'b1111;
  localparam logic [3:0] LED_OFF = 4'b0000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/seq_ctrl.sv
// Memory-game sequencer: replays the first `level` ROM entries on the LEDs,
// then checks player presses against them, growing the round on success.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int T_ON      = 50,
  parameter int T_OFF     = 25,
  parameter int T_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       btn_valid,
  output logic [3:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic [3:0] led,
  output logic [4:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int TW = $clog2(max3(T_ON, T_OFF, T_TIMEOUT) + 1);
  // Timer is loaded with duration-1 so a state lasts exactly its duration.
  localparam logic [TW-1:0] ON_LOAD  = TW'(T_ON - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(T_OFF - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(T_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [4:0]    level_q, level_d;
  logic [3:0]    led_q, led_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          last_step;

  seq_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign last_step = ({1'b0, idx_q} == (level_q - 5'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      level_q <= '0;
      led_q   <= LED_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    level_d  = level_q;
    led_d    = led_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          level_d = 5'd1;
          idx_d   = '0;
          led_d   = LED_OFF;
          state_d = FETCH;
        end
      end
      FETCH: begin
        led_d    = rom_data;
        tmr_load = 1'b1;
        tmr_val  = ON_LOAD;
        state_d  = SHOW_ON;
      end
      SHOW_ON: begin
        if (tmr_done) begin
          led_d    = LED_OFF;
          tmr_load = 1'b1;
          tmr_val  = OFF_LOAD;
          state_d  = SHOW_OFF;
        end
      end
      SHOW_OFF: begin
        if (tmr_done) begin
          if (last_step) begin
            idx_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = TO_LOAD;
            state_d  = WAIT_IN;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = FETCH;
          end
        end
      end
      WAIT_IN: begin
        // A press is evaluated before the timeout so a same-cycle press wins.
        if (btn_valid) begin
          if (btn != rom_data) begin
            state_d = LOSE;
          end else if (!last_step) begin
            idx_d    = idx_q + 4'd1;
            tmr_load = 1'b1;
            tmr_val  = TO_LOAD;
          end else if (level_q == 5'(SEQ_LEN)) begin
            led_d   = LED_ALL;
            state_d = WIN;
          end else begin
            level_d  = level_q + 5'd1;
            idx_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = OFF_LOAD;
            state_d  = GAP;
          end
        end else if (tmr_done) begin
          state_d = LOSE;
        end
      end
      GAP: begin
        if (tmr_done) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    win  = 1'b0;
    lose = 1'b0;
    case (state_q)
      IDLE:    busy = 1'b0;
      WIN:     begin busy = 1'b0; win  = 1'b1; end
      LOSE:    begin busy = 1'b0; lose = 1'b1; end
      default: busy = 1'b1;
    endcase
  end

  assign rom_addr = idx_q;
  assign led      = led_q;
  assign level    = level_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: table-driven opening rounds plus hand-written
// sequences for wrong press, timeout, async reset and a full 16-round game.
module tb_seq_ctrl;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] btn = 4'h0;
  logic       btn_valid = 1'b0;
  logic [3:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] led;
  logic [4:0] level;
  logic       busy, win, lose;

  logic [3:0] rom_mem [16];
  int n_checks = 0;
  int n_fail   = 0;

  assign rom_data = rom_mem[rom_addr];

  seq_ctrl #(.T_ON(4), .T_OFF(2), .T_TIMEOUT(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .btn       (btn),
    .btn_valid (btn_valid),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .led       (led),
    .level     (level),
    .busy      (busy),
    .win       (win),
    .lose      (lose)
  );

  always #5 clk = ~clk;

  // {led, level, busy, win, lose, rom_addr}
  logic [15:0] outs;
  assign outs = {led, level, busy, win, lose, rom_addr};

  typedef struct packed {
    logic       start;
    logic [3:0] btn;
    logic       valid;
    logic [3:0] e_led;
    logic [4:0] e_level;
    logic       e_busy;
    logic       e_win;
    logic       e_lose;
    logic [3:0] e_addr;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic s, input logic [3:0] b, input logic v,
                              input logic [3:0] l, input logic [4:0] lv,
                              input logic [3:0] a);
    vec_t r;
    r.start = s; r.btn = b; r.valid = v;
    r.e_led = l; r.e_level = lv; r.e_busy = 1'b1; r.e_win = 1'b0; r.e_lose = 1'b0;
    r.e_addr = a;
    return r;
  endfunction

  task automatic tick(input logic s, input logic [3:0] b, input logic v);
    @(negedge clk);
    start = s; btn = b; btn_valid = v;
    @(posedge clk);
    #1;
    start = 1'b0; btn = 4'h0; btn_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 4'h0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] one;
    one = 4'b0001;
    for (int i = 0; i < 16; i++) rom_mem[i] = 4'b0001;

    // Opening: start, round 1 replay and press, start of round 2 replay.
    vecs[0]  = mk(1, 4'h0, 0, 4'h0, 5'd1, 4'd0);   // FETCH
    vecs[1]  = mk(0, 4'h0, 0, 4'h1, 5'd1, 4'd0);   // SHOW_ON
    vecs[2]  = mk(1, 4'h1, 1, 4'h1, 5'd1, 4'd0);   // stray start/press ignored
    vecs[3]  = mk(0, 4'h0, 0, 4'h1, 5'd1, 4'd0);
    vecs[4]  = mk(0, 4'h0, 0, 4'h1, 5'd1, 4'd0);
    vecs[5]  = mk(0, 4'h2, 1, 4'h0, 5'd1, 4'd0);   // SHOW_OFF, stray wrong press
    vecs[6]  = mk(0, 4'h0, 0, 4'h0, 5'd1, 4'd0);
    vecs[7]  = mk(0, 4'h0, 0, 4'h0, 5'd1, 4'd0);   // WAIT_IN
    vecs[8]  = mk(0, 4'h1, 1, 4'h0, 5'd2, 4'd0);   // correct -> GAP, level 2
    vecs[9]  = mk(0, 4'h0, 0, 4'h0, 5'd2, 4'd0);
    vecs[10] = mk(0, 4'h0, 0, 4'h0, 5'd2, 4'd0);   // FETCH idx 0
    vecs[11] = mk(0, 4'h0, 0, 4'h1, 5'd2, 4'd0);
    vecs[12] = mk(0, 4'h0, 0, 4'h1, 5'd2, 4'd0);
    vecs[13] = mk(0, 4'h0, 0, 4'h1, 5'd2, 4'd0);
    vecs[14] = mk(0, 4'h0, 0, 4'h1, 5'd2, 4'd0);
    vecs[15] = mk(0, 4'h0, 0, 4'h0, 5'd2, 4'd0);
    vecs[16] = mk(0, 4'h0, 0, 4'h0, 5'd2, 4'd0);
    vecs[17] = mk(0, 4'h0, 0, 4'h0, 5'd2, 4'd1);   // FETCH idx 1
    vecs[18] = mk(0, 4'h0, 0, 4'h1, 5'd2, 4'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(outs), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      tick(vecs[i].start, vecs[i].btn, vecs[i].valid);
      chk($sformatf("vec%0d", i), 32'(outs),
          32'({vecs[i].e_led, vecs[i].e_level, vecs[i].e_busy,
               vecs[i].e_win, vecs[i].e_lose, vecs[i].e_addr}));
    end

    // Finish round 2 replay, then one correct and one wrong press.
    idle(6);
    tick(1'b0, 4'b0001, 1'b1);
    chk("r2_first_press", 32'({lose, level, rom_addr}), 32'({1'b0, 5'd2, 4'd1}));
    tick(1'b0, 4'b0010, 1'b1);
    chk("wrong_press_lose", 32'({lose, busy, win, level, led}), 32'({1'b1, 1'b0, 1'b0, 5'd2, 4'h0}));
    tick(1'b1, 4'h0, 1'b0);
    chk("restart_after_lose", 32'({lose, busy, level, rom_addr}), 32'({1'b0, 1'b1, 5'd1, 4'd0}));
    tick(1'b0, 4'h0, 1'b0);
    chk("replay_resumes", 32'(led), 32'h1);

    // Timeout: 20 idle cycles in WAIT_IN loses.
    idle(6);
    idle(19);
    chk("timeout_not_yet", 32'({lose, busy}), 32'({1'b0, 1'b1}));
    idle(1);
    chk("timeout_lose", 32'({lose, busy, level}), 32'({1'b1, 1'b0, 5'd1}));

    // Press on the expiry cycle counts as a press.
    tick(1'b1, 4'h0, 1'b0);
    idle(7);
    idle(19);
    tick(1'b0, 4'b0001, 1'b1);
    chk("press_at_expiry", 32'({lose, busy, level}), 32'({1'b0, 1'b1, 5'd2}));
    idle(3);
    chk("round2_show", 32'({led, rom_addr}), 32'({4'h1, 4'd0}));

    // Asynchronous reset in the middle of SHOW_ON.
    #2 rst = 1'b1;
    #1;
    chk("async_reset", 32'(outs), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("idle_after_reset", 32'({busy, level}), 32'h0);

    // Full game with varied ROM contents and stray inputs during replay.
    for (int i = 0; i < 16; i++) rom_mem[i] = one << ((i * 3 + 1) % 4);
    tick(1'b1, 4'h0, 1'b0);
    for (int lv = 1; lv <= 16; lv++) begin
      for (int s = 0; s < lv; s++) begin
        tick(1'b0, 4'h0, 1'b0);
        chk($sformatf("game_l%0d_s%0d_show", lv, s), 32'({led, rom_addr}),
            32'({rom_mem[s], 4'(s)}));
        tick(1'b1, ~rom_mem[s], 1'b1);
        idle(5);
      end
      for (int s = 0; s < lv; s++) tick(1'b0, rom_mem[s], 1'b1);
      if (lv < 16) begin
        idle(2);
        chk($sformatf("game_l%0d_done", lv), 32'({lose, busy, level}),
            32'({1'b0, 1'b1, 5'(lv + 1)}));
      end
    end
    chk("game_win", 32'({win, lose, busy, led, level}),
        32'({1'b1, 1'b0, 1'b0, 4'b1111, 5'd16}));
    tick(1'b1, 4'h0, 1'b0);
    chk("restart_after_win", 32'({win, busy, led, level}),
        32'({1'b0, 1'b1, 4'h0, 5'd1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
